sig_debounce: RTL and testbench

SIG_DEBOUNCE -- requirements
Module: sig_debounce

---
 rtl/sig_debounce.sv | 142 ++++++++++++++
 tb/tb_sig_debounce.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_debounce.sv
// Debouncer: synchronizes A, then requires hold cycles of stability before B follows.
// Optional glitch counter enabled by defining SIG_DEBOUNCE_GLITCH_CNT_EN.
module sig_debounce #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic [3:0] hold,
    output logic       B,
    output logic       rise,
    output logic       fall
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] hold_lat_reg, hold_lat_next;
    logic [3:0] hold_eff;
    logic       b_reg, b_next;
    logic       rise_reg, rise_next;
    logic       fall_reg, fall_next;

    // Only the first synchronizer stage ever samples the raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], A};
        end
    end

    assign s        = sync_reg[SYNC_STAGES-1];
    assign hold_eff = (hold == 4'd0) ? 4'd1 : hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= LOW;
            cnt_reg      <= 4'd0;
            hold_lat_reg <= 4'd0;
            b_reg        <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            hold_lat_reg <= hold_lat_next;
            b_reg        <= b_next;
            rise_reg     <= rise_next;
            fall_reg     <= fall_next;
        end
    end

    // cnt only advances while below the latched window (<=15), so it cannot wrap.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        hold_lat_next = hold_lat_reg;
        rise_next     = 1'b0;
        fall_next     = 1'b0;
        case (state_reg)
            LOW: begin
                if (s) begin
                    state_next    = RISE_CHK;
                    cnt_next      = 4'd1;
                    hold_lat_next = hold_eff;
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    state_next = LOW;
                    cnt_next   = 4'd0;
                end else if (cnt_reg >= hold_lat_reg) begin
                    state_next = HIGH;
                    cnt_next   = 4'd0;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_next    = FALL_CHK;
                    cnt_next      = 4'd1;
                    hold_lat_next = hold_eff;
                end
            end
            FALL_CHK: begin
                if (s) begin
                    state_next = HIGH;
                    cnt_next   = 4'd0;
                end else if (cnt_reg >= hold_lat_reg) begin
                    state_next = LOW;
                    cnt_next   = 4'd0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = LOW;
                cnt_next   = 4'd0;
            end
        endcase
        b_next = (state_next == HIGH) || (state_next == FALL_CHK);
    end

    assign B    = b_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    logic       glitch;
    logic [7:0] glitch_reg;

    assign glitch = ((state_reg == RISE_CHK) && !s) || ((state_reg == FALL_CHK) && s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_reg <= 8'd0;
        end else if (glitch && (glitch_reg != 8'd255)) begin
            glitch_reg <= glitch_reg + 8'd1;
        end
    end

    assign glitch_cnt = glitch_reg;
`endif

endmodule

// File: tb/tb_sig_debounce.sv
// Self-checking bench for sig_debounce: directed timing scenarios plus randomized
// stimulus compared against a run-length reference model.
module tb_sig_debounce;

    localparam int SS = 2;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic [3:0] hold;
    logic       b;
    logic       rise;
    logic       fall;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] gcnt;
`endif

    int nchk;
    int nerr;

    sig_debounce #(.SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .hold  (hold),
        .B     (b),
        .rise  (rise),
        .fall  (fall)
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (gcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: B follows s once s has disagreed with B for hold_eff+1
    // consecutive cycles; hold_eff is taken at the start of the disagreement run.
    logic [SS-1:0] m_hist;
    logic          m_b, m_rise, m_fall;
    int            m_run, m_h, m_gc;

    function automatic void model_step(
        input  logic s_in, input logic [3:0] hold_in,
        input  logic b_in, input int run_in, input int h_in, input int gc_in,
        output logic b_out, output logic r_out, output logic f_out,
        output int run_out, output int h_out, output int gc_out);
        b_out = b_in; r_out = 1'b0; f_out = 1'b0;
        run_out = run_in; h_out = h_in; gc_out = gc_in;
        if (s_in != b_in) begin
            run_out = run_in + 1;
            if (run_out == 1) h_out = (hold_in == 4'd0) ? 1 : int'(hold_in);
            if (run_out == h_out + 1) begin
                b_out = s_in; r_out = s_in; f_out = !s_in; run_out = 0;
            end
        end else begin
            if (run_in > 0 && gc_in < 255) gc_out = gc_in + 1;
            run_out = 0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic nb, nr, nf;
        int nrun, nh, ngc;
        if (!rst_n) begin
            m_hist <= '0; m_b <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0;
            m_run <= 0; m_h <= 1; m_gc <= 0;
        end else begin
            model_step(m_hist[SS-1], hold, m_b, m_run, m_h, m_gc, nb, nr, nf, nrun, nh, ngc);
            m_hist <= {m_hist[SS-2:0], a};
            m_b <= nb; m_rise <= nr; m_fall <= nf;
            m_run <= nrun; m_h <= nh; m_gc <= ngc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; a = 1'b1; hold = 4'd3;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        nchk++;
        if ({b, rise, fall} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_outputs: got B/rise/fall=%b required 000", {b, rise, fall});
        end
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        nchk++;
        if (gcnt !== 8'd0) begin
            nerr++;
            $display("FAIL reset_glitch_cnt: got %0d required 0", gcnt);
        end
`endif
        a = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        $display("test_reset: B=%b rise=%b fall=%b", b, rise, fall);
    endtask

    task automatic test_rise_timing();
        do_reset();
        hold = 4'd3;
        a = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            nchk++;
            if (b !== (k >= 6) || rise !== (k == 6) || fall !== 1'b0) begin
                nerr++;
                $display("FAIL rise_timing edge %0d: got B/rise/fall=%b%b%b required %b%b0",
                         k, b, rise, fall, k >= 6, k == 6);
            end
        end
        $display("test_rise_timing: hold=3 B=%b after 9 edges", b);
    endtask

    task automatic test_glitch();
        do_reset();
        hold = 4'd3;
        a = 1'b1;
        repeat (2) tick();
        a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            nchk++;
            if ({b, rise, fall} !== 3'b000) begin
                nerr++;
                $display("FAIL short_pulse cycle %0d: got B/rise/fall=%b required 000", k, {b, rise, fall});
            end
        end
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        nchk++;
        if (gcnt !== 8'd1) begin
            nerr++;
            $display("FAIL short_pulse_glitch_cnt: got %0d required 1", gcnt);
        end
`endif
        $display("test_glitch: 2-cycle pulse with hold=3, B=%b", b);
    endtask

    task automatic test_hold_zero();
        do_reset();
        hold = 4'd0;
        a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            nchk++;
            if (b !== (k >= 4) || rise !== (k == 4)) begin
                nerr++;
                $display("FAIL hold_zero edge %0d: got B/rise=%b%b required %b%b", k, b, rise, k >= 4, k == 4);
            end
        end
        $display("test_hold_zero: B=%b", b);
    endtask

    task automatic test_fall_glitch();
        do_reset();
        hold = 4'd5;
        a = 1'b1;
        repeat (12) tick();
        nchk++;
        if (b !== 1'b1) begin
            nerr++;
            $display("FAIL fall_setup: got B=%b required 1", b);
        end
        a = 1'b0;
        repeat (4) tick();
        a = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            nchk++;
            if (b !== 1'b1 || fall !== 1'b0 || rise !== 1'b0) begin
                nerr++;
                $display("FAIL low_glitch cycle %0d: got B/rise/fall=%b%b%b required 100", k, b, rise, fall);
            end
        end
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        nchk++;
        if (gcnt !== 8'd1) begin
            nerr++;
            $display("FAIL low_glitch_cnt: got %0d required 1", gcnt);
        end
`endif
        a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            nchk++;
            if (b !== (k < 8) || fall !== (k == 8) || rise !== 1'b0) begin
                nerr++;
                $display("FAIL fall_timing edge %0d: got B/fall=%b%b required %b%b", k, b, fall, k < 8, k == 8);
            end
        end
        $display("test_fall_glitch: hold=5 B=%b", b);
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold = 4'd3;
        a = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            nchk++;
            if ({b, rise, fall} !== 3'b000) begin
                nerr++;
                $display("FAIL mid_reset cycle %0d: got B/rise/fall=%b required 000", k, {b, rise, fall});
            end
            tick();
        end
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        nchk++;
        if (gcnt !== 8'd0) begin
            nerr++;
            $display("FAIL mid_reset_glitch_cnt: got %0d required 0", gcnt);
        end
`endif
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            nchk++;
            if (b !== (k >= 6) || rise !== (k == 6)) begin
                nerr++;
                $display("FAIL post_reset_rise edge %0d: got B/rise=%b%b required %b%b", k, b, rise, k >= 6, k == 6);
            end
        end
        $display("test_reset_mid: B=%b after release", b);
    endtask

    task automatic test_random();
        int run_left;
        logic prev_rise, prev_fall;
        do_reset();
        run_left = 0;
        prev_rise = 1'b0;
        prev_fall = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) hold = 4'($urandom_range(0, 15));
            if (run_left == 0) begin
                a = ~a;
                run_left = $urandom_range(1, 20);
            end
            run_left--;
            tick();
            nchk++;
            if (b !== m_b || rise !== m_rise || fall !== m_fall) begin
                nerr++;
                $display("FAIL random cycle %0d: got B/rise/fall=%b%b%b required %b%b%b",
                         k, b, rise, fall, m_b, m_rise, m_fall);
            end
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
            nchk++;
            if (int'(gcnt) !== m_gc) begin
                nerr++;
                $display("FAIL random_glitch_cnt cycle %0d: got %0d required %0d", k, gcnt, m_gc);
            end
`endif
            nchk++;
            if ((rise && fall) || (rise && prev_rise) || (fall && prev_fall)) begin
                nerr++;
                $display("FAIL pulse_shape cycle %0d: got rise=%b fall=%b prev=%b%b required single pulses",
                         k, rise, fall, prev_rise, prev_fall);
            end
            prev_rise = rise;
            prev_fall = fall;
        end
        $display("test_random: 3000 cycles, model glitches=%0d", m_gc);
    endtask

    task automatic test_saturate();
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        do_reset();
        hold = 4'd5;
        for (int g = 0; g < 305; g++) begin
            a = 1'b1;
            repeat (2) tick();
            a = 1'b0;
            repeat (6) tick();
            if (g == 299 || g == 304) begin
                nchk++;
                if (gcnt !== 8'd255 || b !== 1'b0) begin
                    nerr++;
                    $display("FAIL saturate after %0d glitches: got cnt=%0d B=%b required 255 B=0", g + 1, gcnt, b);
                end
            end
        end
        $display("test_saturate: glitch_cnt=%0d", gcnt);
`else
        $display("test_saturate: glitch counter not built");
`endif
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        a = 1'b0;
        hold = 4'd3;
        repeat (2) tick();
        test_reset();
        test_rise_timing();
        test_glitch();
        test_hold_zero();
        test_fall_glitch();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
